// File: rtl/rs485_rx_fifo_pkg.sv
// Shared constants and status payload types for the RS-485 Rx byte buffer.
package rs485_rx_fifo_pkg;

    localparam int unsigned RS485_DATA_W       = 8;
    localparam int unsigned RS485_RXFIFO_DEPTH = 16;
    localparam int unsigned RS485_ERRCNT_W     = 8;

    // APB register offsets served by this block
    localparam logic [7:0] RS485_APB_RXDATA   = 8'h04;
    localparam logic [7:0] RS485_APB_RXSTATUS = 8'h08;
    localparam logic [7:0] RS485_APB_ERRCNT   = 8'h0C;

    localparam int unsigned RS485_CNT_W = $clog2(RS485_RXFIFO_DEPTH) + 1;

    // Rx status word layout as presented on the APB read bus
    typedef struct packed {
        logic                   overrun;
        logic                   full;
        logic                   empty;
        logic [RS485_CNT_W-1:0] count;
    } rx_status_t;

endpackage

// File: rtl/rs485_fifo_mem.sv
// Dual-port register array: synchronous write, registered read.
module rs485_fifo_mem #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage write; contents are not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register; a same-edge write to raddr returns the old entry
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/rs485_rx_fifo.sv
// Rx byte buffer between the RS-485 deserializer and the APB register file.
module rs485_rx_fifo
    import rs485_rx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH  = RS485_RXFIFO_DEPTH,
    parameter int unsigned DATA_W = RS485_DATA_W,
    parameter int unsigned CNT_W  = RS485_ERRCNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_valid,
    input  logic [DATA_W-1:0]      rx_data,
    input  logic                   rx_frame_err,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_valid,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overrun,
    input  logic                   clr_status,
    output logic [CNT_W-1:0]       err_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count_q;
    logic             overrun_q;
    logic [CNT_W-1:0] err_q;
    logic             rd_valid_q;

    logic rd_pop;
    logic wr_acc;
    logic ovf_evt;
    logic err_evt;

    // Event decode from the registered occupancy
    always_comb begin
        rd_pop  = rd_en & ~empty;
        wr_acc  = rx_valid & ~rx_frame_err & (~full | rd_pop);
        ovf_evt = rx_valid & ~rx_frame_err & full & ~rd_pop;
        err_evt = rx_valid & rx_frame_err;
    end

    // Pointers, occupancy and read-valid pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_pop) begin
                rptr <= rptr + AW'(1);
            end
            count_q    <= count_q + CW'(wr_acc) - CW'(rd_pop);
            rd_valid_q <= rd_pop;
        end
    end

    // Sticky overrun and saturating frame-error count; a same-cycle event beats the clear
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
            err_q     <= '0;
        end else begin
            if (ovf_evt) begin
                overrun_q <= 1'b1;
            end else if (clr_status) begin
                overrun_q <= 1'b0;
            end

            if (err_evt) begin
                if (clr_status) begin
                    err_q <= CNT_W'(1);
                end else if (!(&err_q)) begin
                    err_q <= err_q + CNT_W'(1);
                end
            end else if (clr_status) begin
                err_q <= '0;
            end
        end
    end

    rs485_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wptr),
        .wdata (rx_data),
        .re    (rd_pop),
        .raddr (rptr),
        .rdata (rd_data)
    );

    // Status decodes of the registered state
    always_comb begin
        count     = count_q;
        empty     = (count_q == '0);
        full      = (count_q == CW'(DEPTH));
        overrun   = overrun_q;
        err_count = err_q;
        rd_valid  = rd_valid_q;
    end

endmodule

// File: tb/tb_rs485_rx_fifo.sv
// Self-checking bench for rs485_rx_fifo: vector table plus scoreboarded sequences.
module tb_rs485_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_frame_err;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overrun;
    logic       clr_status;
    logic [7:0] err_count;

    always #5 clk = ~clk;

    rs485_rx_fifo #(.DEPTH(16), .DATA_W(8), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_frame_err (rx_frame_err),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .overrun      (overrun),
        .clr_status   (clr_status),
        .err_count    (err_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] m_q[$];
    logic [7:0] sb_q[$];
    logic       m_ovr  = 1'b0;
    int         m_err  = 0;
    logic [7:0] m_last = 8'h00;

    typedef struct {
        logic       rv;
        logic [7:0] d;
        logic       re;
        int         gap;
        logic [4:0] e_cnt;
        logic       e_rdv;
        logic [7:0] e_rdd;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_status();
        check("count",     32'(count),     32'(m_q.size()));
        check("empty",     32'(empty),     32'(m_q.size() == 0));
        check("full",      32'(full),      32'(m_q.size() == DEPTH));
        check("overrun",   32'(overrun),   32'(m_ovr));
        check("err_count", 32'(err_count), 32'(m_err));
    endtask

    // One clock of stimulus with model update and output checks
    task automatic cycle(input logic rv, input logic [7:0] d, input logic fe,
                         input logic re, input logic clr);
        bit         full_pre;
        bit         popped;
        logic [7:0] exp;
        full_pre = (m_q.size() == DEPTH);
        popped   = re && (m_q.size() != 0);
        if (popped) sb_q.push_back(m_q.pop_front());
        if (rv && !fe && (!full_pre || popped)) m_q.push_back(d);
        if (rv && !fe && full_pre && !popped) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        if (rv && fe) m_err = clr ? 1 : ((m_err == 255) ? 255 : m_err + 1);
        else if (clr) m_err = 0;

        rx_valid = rv; rx_data = d; rx_frame_err = fe; rd_en = re; clr_status = clr;
        @(posedge clk);
        #1;
        rx_valid = 1'b0; rx_frame_err = 1'b0; rd_en = 1'b0; clr_status = 1'b0;

        if (popped) begin
            exp = sb_q.pop_front();
            check("rd_valid", 32'(rd_valid), 32'd1);
            check("rd_data",  32'(rd_data),  32'(exp));
            m_last = exp;
        end else begin
            check("rd_valid_idle", 32'(rd_valid), 32'd0);
            check("rd_data_hold",  32'(rd_data),  32'(m_last));
        end
        check_status();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_valid = 1'b0; rx_frame_err = 1'b0; rd_en = 1'b0; clr_status = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_q.delete(); sb_q.delete();
        m_ovr = 1'b0; m_err = 0; m_last = 8'h00;
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data",  32'(rd_data),  32'd0);
        check_status();
    endtask

    task automatic push(input logic [7:0] d);
        cycle(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_frame_err = 1'b0;
        rd_en = 1'b0; clr_status = 1'b0;

        //               rv    d      re   gap cnt  rdv   rdd
        vecs[0] = '{1'b1, 8'h02, 1'b0, 10, 5'd1, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 8'h01, 1'b0, 10, 5'd2, 1'b0, 8'h00};
        vecs[2] = '{1'b1, 8'h41, 1'b0, 10, 5'd3, 1'b0, 8'h00};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 0,  5'd2, 1'b1, 8'h02};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 0,  5'd1, 1'b1, 8'h01};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 0,  5'd0, 1'b1, 8'h41};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 0,  5'd0, 1'b0, 8'h41};
        vecs[7] = '{1'b1, 8'h99, 1'b1, 0,  5'd1, 1'b0, 8'h41};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 0,  5'd0, 1'b1, 8'h99};
        vecs[9] = '{1'b0, 8'h00, 1'b0, 0,  5'd0, 1'b0, 8'h99};

        repeat (2) @(posedge clk);
        do_reset();

        // Basic ordering, empty reads, write+read on empty
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].rv, vecs[i].d, 1'b0, vecs[i].re, 1'b0);
            check($sformatf("vec%0d_count", i),    32'(count),    32'(vecs[i].e_cnt));
            check($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].e_rdv));
            check($sformatf("vec%0d_rd_data", i),  32'(rd_data),  32'(vecs[i].e_rdd));
            repeat (vecs[i].gap) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end

        // Overfill by one: 0x10 dropped, overrun set
        for (int i = 0; i <= 16; i++) begin
            push(8'(i));
            if (i == 15) check("full_after_16", 32'(full), 32'd1);
        end
        check("overrun_set", 32'(overrun), 32'd1);
        for (int i = 0; i < 16; i++) pop();
        check("drain_last", 32'(rd_data), 32'h0F);

        // Full FIFO with simultaneous write and pop
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) push(8'(8'h30 + i));
        cycle(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
        check("full_rw_count",   32'(count),   32'd16);
        check("full_rw_overrun", 32'(overrun), 32'd0);
        check("full_rw_data",    32'(rd_data), 32'h30);
        for (int i = 0; i < 16; i++) pop();
        check("full_rw_last", 32'(rd_data), 32'hAA);

        // Frame errors, clear, clear-vs-event, saturation
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        check("ferr_count3", 32'(err_count), 32'd3);
        check("ferr_nostore", 32'(count), 32'd0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("ferr_clr", 32'(err_count), 32'd0);
        cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
        check("ferr_clr_race", 32'(err_count), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 256; i++) cycle(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
        check("ferr_sat", 32'(err_count), 32'hFF);
        cycle(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        check("ferr_sat_hold", 32'(err_count), 32'hFF);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Overrun in the same cycle as clr_status: event wins
        for (int i = 0; i < 16; i++) push(8'(8'hC0 + i));
        cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        check("ovr_clr_race", 32'(overrun), 32'd1);

        // Reset mid-stream after partial refill
        for (int i = 0; i < 16; i++) pop();
        for (int i = 0; i < 5; i++) push(8'(8'h70 + i));
        cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        do_reset();
        check("post_rst_count", 32'(count), 32'd0);
        check("post_rst_empty", 32'(empty), 32'd1);
        push(8'h5A);
        pop();
        check("post_rst_rt", 32'(rd_data), 32'h5A);

        // Wrap: 40 simultaneous push/pop with a small preload
        for (int i = 0; i < 3; i++) push(8'(8'h80 + i));
        for (int i = 0; i < 40; i++) cycle(1'b1, 8'(8'h90 + i), 1'b0, 1'b1, 1'b0);
        check("wrap_count", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) pop();
        check("wrap_last", 32'(rd_data), 32'(8'h90 + 39));

        // Random mix against the model
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom),
                  1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 19) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
